// File: rtl/lego_psum_collector.sv
// lego_psum_collector: output-side collector for the 64-lane Lego systolic array.
// Partial-sum rows are accumulated across cfg_ktiles K-tiles in a row buffer and
// the finished rows are drained downstream over a valid/ready handshake.
// Optional feature macro: LEGO_PSUM_RELU_EN (clamp negative output lanes to 0).
module lego_psum_collector #(
  parameter int DATA_W_OUT = 32,
  parameter int ACC_W      = 32,
  parameter int LANES      = 64,
  parameter int MAX_ROWS   = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [$clog2(MAX_ROWS):0]        cfg_rows,
  input  logic [7:0]                       cfg_ktiles,
  input  logic [1:0]                       cfg_type,
  input  logic [LANES-1:0][DATA_W_OUT-1:0] psum_in,
  input  logic                             psum_valid,
  output logic [LANES-1:0][ACC_W-1:0]      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int ROWS_W = $clog2(MAX_ROWS) + 1;
  localparam int PTR_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;
  typedef logic [LANES-1:0][ACC_W-1:0] row_t;

  state_e             state_q, state_d;
  logic [ROWS_W-1:0]  rows_q, rows_d;
  logic [7:0]         ktiles_q, ktiles_d;
  logic [1:0]         type_q, type_d;
  logic [PTR_W-1:0]   row_ptr_q, row_ptr_d;
  logic [7:0]         tile_cnt_q, tile_cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  row_t               row_buf [MAX_ROWS];
  row_t               acc_row;
  logic               buf_we;
  logic signed [ACC_W-1:0] psum_ext;

  logic cfg_legal;
  logic row_last, tile_last, rd_last;

  assign cfg_legal = (cfg_rows != '0) && (cfg_rows <= ROWS_W'(MAX_ROWS)) &&
                     (cfg_ktiles != 8'd0) && (cfg_type != 2'd3);
  assign row_last  = (ROWS_W'(row_ptr_q) == rows_q - ROWS_W'(1));
  assign tile_last = (tile_cnt_q == ktiles_q - 8'd1);
  assign rd_last   = (ROWS_W'(rd_ptr_q) == rows_q - ROWS_W'(1));

  // State register: async reset abandons any job and returns to IDLE.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_start && cfg_legal)             state_d = S_ACCUM;
      S_ACCUM: if (psum_valid && row_last && tile_last) state_d = S_DRAIN;
      S_DRAIN: if (out_ready && rd_last)                state_d = S_IDLE;
      default:                                          state_d = S_IDLE;
    endcase
  end

  // Output logic: DRAIN presents buf[rd_ptr]; out_data is zero whenever not valid.
  always_comb begin
    out_valid = (state_q == S_DRAIN);
    out_last  = out_valid && rd_last;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    err       = err_q;
    out_data  = '0;
    if (out_valid) begin
      out_data = row_buf[rd_ptr_q];
`ifdef LEGO_PSUM_RELU_EN
      for (int i = 0; i < LANES; i++) begin
        if (out_data[i][ACC_W-1]) out_data[i] = '0;
      end
`endif
    end
  end

  // Row written back to the buffer: first tile loads, later tiles add; inactive lanes are 0.
  always_comb begin
    acc_row  = '0;
    psum_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      psum_ext = $signed(psum_in[i]);
      if (i < (LANES >> type_q)) begin
        acc_row[i] = (tile_cnt_q == 8'd0) ? psum_ext : row_buf[row_ptr_q][i] + psum_ext;
      end
    end
  end

  // Datapath control: config latch, pointers, tile counter, done/err pulses.
  always_comb begin
    rows_d     = rows_q;
    ktiles_d   = ktiles_q;
    type_d     = type_q;
    row_ptr_d  = row_ptr_q;
    tile_cnt_d = tile_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    buf_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_legal) begin
            rows_d     = cfg_rows;
            ktiles_d   = cfg_ktiles;
            type_d     = cfg_type;
            row_ptr_d  = '0;
            tile_cnt_d = '0;
            rd_ptr_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        // A row arriving outside ACCUM is dropped, even alongside an accepted start.
        if (psum_valid) err_d = 1'b1;
      end
      S_ACCUM: begin
        if (cfg_start) err_d = 1'b1;
        if (psum_valid) begin
          buf_we = 1'b1;
          if (row_last) begin
            row_ptr_d  = '0;
            tile_cnt_d = tile_cnt_q + 8'd1;
          end else begin
            row_ptr_d = row_ptr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (cfg_start || psum_valid) err_d = 1'b1;
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_last) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q     <= '0;
      ktiles_q   <= '0;
      type_q     <= '0;
      row_ptr_q  <= '0;
      tile_cnt_q <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      ktiles_q   <= ktiles_d;
      type_q     <= type_d;
      row_ptr_q  <= row_ptr_d;
      tile_cnt_q <= tile_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Row buffer write port.
  // NOTE: the buffer has no reset; tile 0 overwrites every row before it is ever read.
  always_ff @(posedge clk) begin
    if (buf_we) row_buf[row_ptr_q] <= acc_row;
  end

endmodule

// File: tb/tb_lego_psum_collector.sv
// Self-checking bench for lego_psum_collector: directed test-plan jobs plus
// randomized jobs, checked against per-job tile sums kept in the bench.
module tb_lego_psum_collector;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LANES = 64;
  localparam int MAX_ROWS = 64;

  typedef logic [LANES-1:0][AW-1:0] row_t;
  typedef struct { row_t data; bit last; } exp_t;

  logic clk = 1'b0;
  logic rst_n, cfg_start, psum_valid, out_ready;
  logic [6:0] cfg_rows;
  logic [7:0] cfg_ktiles;
  logic [1:0] cfg_type;
  logic [LANES-1:0][DW-1:0] psum_in;
  row_t out_data;
  logic out_valid, out_last, busy, done, err;

  int n_checks = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int jobs_done = 0;
  exp_t exp_q[$];
  row_t got_q[$];
  logic [31:0] tile_val [16];
  bit stall_prev = 1'b0;
  row_t prev_data;
  int bad_rows [4] = '{0, 65, 4, 4};
  int bad_kt   [4] = '{1, 1, 0, 1};
  int bad_ty   [4] = '{0, 0, 0, 3};

  lego_psum_collector #(
    .DATA_W_OUT(DW), .ACC_W(AW), .LANES(LANES), .MAX_ROWS(MAX_ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_rows(cfg_rows),
    .cfg_ktiles(cfg_ktiles), .cfg_type(cfg_type), .psum_in(psum_in),
    .psum_valid(psum_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_row(input string name, input row_t act, input row_t exp);
    int bad = 0;
    for (int l = LANES - 1; l >= 0; l--) if (act[l] !== exp[l]) bad = l;
    check($sformatf("%s lane%0d", name, bad), 64'(act[bad]), 64'(exp[bad]));
  endtask

  function automatic logic [31:0] got_lane(input int row, input int lane);
    if (row < got_q.size()) return got_q[row][lane];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    logic [3:0] pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[3 - (cyc % 4)];
    return 1'($urandom_range(0, 1));
  endfunction

  // Compare process: every cycle, outputs against the expected-row queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", 64'(out_valid), 64'd0);
        end else begin
          check_row("drain data", out_data, exp_q[0].data);
          check("out_last", 64'(out_last), 64'(exp_q[0].last));
          if (stall_prev) check_row("stall hold", out_data, prev_data);
          if (out_ready) begin
            got_q.push_back(out_data);
            exp_q.delete(0);
          end
        end
      end else begin
        check_row("idle out_data zero", out_data, '0);
        check("idle out_last", 64'(out_last), 64'd0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // One complete job. src 0: random lanes; src 1: all lanes = tile_val[row sequence].
  // rdy_mode 0: ready high; 1: 1,0,0,1 pattern; 2: random.
  // inj bit0: psum with start; bit1: start during ACCUM; bit2: start+psum during DRAIN.
  task automatic run_job(input int rows, input int kt, input int typ, input int src,
                         input int rdy_mode, input int inj);
    row_t exp_rows [MAX_ROWS];
    int active, err0, done0, err_exp, seq, cyc, budget;
    logic [31:0] v;
    active  = LANES >> typ;
    err0    = err_cnt;
    done0   = done_cnt;
    err_exp = 0;
    seq     = 0;
    got_q.delete();
    for (int r = 0; r < MAX_ROWS; r++) exp_rows[r] = '0;

    cfg_rows = 7'(rows); cfg_ktiles = 8'(kt); cfg_type = 2'(typ); cfg_start = 1'b1;
    if (inj[0]) begin
      psum_valid = 1'b1;
      psum_in = {LANES{32'hDEAD_BEEF}};
      err_exp++;
    end
    @(posedge clk); #1;
    cfg_start = 1'b0; psum_valid = 1'b0;

    for (int t = 0; t < kt; t++) begin
      for (int r = 0; r < rows; r++) begin
        if ((inj[1] && t == kt - 1 && r == 0) ||
            (!(t == 0 && r == 0) && $urandom_range(0, 3) == 0)) begin
          if (inj[1] && t == kt - 1 && r == 0) begin
            cfg_start = 1'b1;
            err_exp++;
          end
          psum_valid = 1'b0;
          @(posedge clk); #1;
          cfg_start = 1'b0;
        end
        for (int l = 0; l < LANES; l++) begin
          v = (src == 1) ? tile_val[seq] : $urandom;
          psum_in[l] = v;
          if (l < active) exp_rows[r][l] = exp_rows[r][l] + v;
        end
        seq++;
        psum_valid = 1'b1;
        if (t == 0 && r == 0) begin
          @(negedge clk);
          check("busy in accum", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
      end
    end
    psum_valid = 1'b0;

    for (int r = 0; r < rows; r++) begin
`ifdef LEGO_PSUM_RELU_EN
      for (int l = 0; l < LANES; l++) if (exp_rows[r][l][AW-1]) exp_rows[r][l] = '0;
`endif
      exp_q.push_back('{data: exp_rows[r], last: (r == rows - 1)});
    end

    cyc = 0;
    out_ready = pick_ready(rdy_mode, 0);
    @(negedge clk);
    check("out_valid no bubble", 64'(out_valid), 64'd1);
    check("busy in drain", 64'(busy), 64'd1);
    @(posedge clk); #1;
    budget = rows * 40 + 40;
    while (exp_q.size() > 0 && cyc < budget) begin
      cyc++;
      out_ready = pick_ready(rdy_mode, cyc);
      if (inj[2] && cyc == 1) begin
        cfg_start = 1'b1;
        err_exp++;
      end
      if (inj[2] && cyc == 2) begin
        psum_valid = 1'b1;
        psum_in = {LANES{32'h1234_5678}};
        err_exp++;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0; psum_valid = 1'b0;
    end
    check("drain within budget", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    @(negedge clk); #1;
    check("done pulse", 64'(done), 64'd1);
    check("busy after done", 64'(busy), 64'd0);
    check("out_valid after last", 64'(out_valid), 64'd0);
    check("one done per job", 64'(done_cnt - done0), 64'd1);
    check("err pulses", 64'(err_cnt - err0), 64'(err_exp));
    check("rows transferred", 64'(got_q.size()), 64'(rows));
    jobs_done++;
  endtask

  initial begin
    int rows, kt, typ;
    rst_n = 1'b0; cfg_start = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    cfg_rows = '0; cfg_ktiles = '0; cfg_type = '0; psum_in = '0;

    // Reset state.
    #2;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check_row("reset out_data", out_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, 2 rows, 1 tile: all-5 then all-(-3).
    tile_val[0] = 32'd5; tile_val[1] = 32'hFFFF_FFFD;
    run_job(2, 1, 0, 1, 0, 0);
    check("t1 row0 lane0", 64'(got_lane(0, 0)), 64'd5);
    check("t1 row0 lane63", 64'(got_lane(0, 63)), 64'd5);
`ifdef LEGO_PSUM_RELU_EN
    check("t1 row1 lane17", 64'(got_lane(1, 17)), 64'd0);
`else
    check("t1 row1 lane17", 64'(got_lane(1, 17)), 64'hFFFF_FFFD);
`endif

    // Mode 1, 1 row, 3 tiles: 10 + 20 - 7.
    tile_val[0] = 32'd10; tile_val[1] = 32'd20; tile_val[2] = 32'hFFFF_FFF9;
    run_job(1, 3, 1, 1, 0, 0);
    check("t2 lane0", 64'(got_lane(0, 0)), 64'd23);
    check("t2 lane31", 64'(got_lane(0, 31)), 64'd23);
    check("t2 lane32", 64'(got_lane(0, 32)), 64'd0);
    check("t2 lane63", 64'(got_lane(0, 63)), 64'd0);
    tile_val[2] = 32'hFFFF_FFD8;
    run_job(1, 3, 1, 1, 0, 0);
`ifdef LEGO_PSUM_RELU_EN
    check("t2 neg lane5", 64'(got_lane(0, 5)), 64'd0);
`else
    check("t2 neg lane5", 64'(got_lane(0, 5)), 64'hFFFF_FFF6);
`endif

    // Mode 2, 4 rows, 2 tiles, ready toggling 1,0,0,1.
    run_job(4, 2, 2, 0, 1, 0);
    check("t3 inactive lane16", 64'(got_lane(3, 16)), 64'd0);

    // Wrap modulo 2^32.
    tile_val[0] = 32'h7FFF_FFFF; tile_val[1] = 32'd1;
    run_job(1, 2, 0, 1, 0, 0);
`ifdef LEGO_PSUM_RELU_EN
    check("t4 wrap lane5", 64'(got_lane(0, 5)), 64'd0);
`else
    check("t4 wrap lane5", 64'(got_lane(0, 5)), 64'h8000_0000);
`endif

    // Illegal configs are ignored with an err pulse.
    for (int i = 0; i < 4; i++) begin
      cfg_rows = 7'(bad_rows[i]); cfg_ktiles = 8'(bad_kt[i]); cfg_type = 2'(bad_ty[i]);
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      check($sformatf("illegal cfg %0d err", i), 64'(err), 64'd1);
      check($sformatf("illegal cfg %0d busy", i), 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    // psum_valid in IDLE.
    psum_valid = 1'b1;
    @(posedge clk); #1;
    psum_valid = 1'b0;
    @(negedge clk);
    check("idle psum err", 64'(err), 64'd1);
    check("idle psum busy", 64'(busy), 64'd0);
    check("idle psum out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    // Protocol errors injected in every state during a real job.
    run_job(6, 2, 0, 0, 1, 7);

    // Reset in the middle of ACCUM.
    cfg_rows = 7'd8; cfg_ktiles = 8'd2; cfg_type = 2'd0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (5) begin
      for (int l = 0; l < LANES; l++) psum_in[l] = $urandom;
      psum_valid = 1'b1;
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset err", 64'(err), 64'd0);
    check_row("mid reset out_data", out_data, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8, 2, 0, 0, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      typ  = $urandom_range(0, 2);
      rows = ($urandom_range(0, 3) == 0) ? MAX_ROWS : $urandom_range(1, MAX_ROWS);
      kt   = $urandom_range(1, 4);
      run_job(rows, kt, typ, 0, 2, $urandom_range(0, 7));
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("total done pulses", 64'(done_cnt), 64'(jobs_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lego_psum_collector.md
# lego_psum_collector

Output-side collector for the 64-lane Lego systolic array. It takes the row-by-row partial-sum vectors the array emits and accumulates them across a programmed number of K-tiles in an on-block row buffer. It then drains the finished output rows to the downstream requant/writeback stage over a valid/ready handshake. Lane packing follows the array's mode encoding: mode 0 uses 64 lanes, mode 1 uses 32 and mode 2 uses 16.

## Interface
Parameters:
- DATA_W_OUT, 32, width of each incoming partial-sum lane
- ACC_W, 32, accumulator / output lane width (≥ DATA_W_OUT)
- LANES, 64, lanes per row
- MAX_ROWS, 64, row-buffer depth

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle job start pulse
- cfg_rows  in  $clog2(MAX_ROWS)+1  rows per tile, legal 1..MAX_ROWS
- cfg_ktiles  in  8  K-tiles to accumulate, legal 1..255
- cfg_type  in  2  lane mode: 0→64 lanes, 1→32 lanes, 2→16 lanes; 3 illegal
- psum_in  in  [LANES] x DATA_W_OUT  partial-sum row from the array
- psum_valid  in  1  psum_in holds a valid row this cycle
- out_data  out  [LANES] x ACC_W  finished output row
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks the final row of the job
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse when a job completes
- err  out  1  one-cycle protocol-error pulse

## Operation
- FSM states are IDLE, ACCUM and DRAIN. Reset enters IDLE.
- **IDLE:**
  - A cfg_start with a legal cfg_rows/cfg_ktiles/cfg_type latches the config, clears row_ptr, tile_cnt and rd_ptr, and moves to ACCUM.
  - An illegal config (rows 0, rows > MAX_ROWS, ktiles 0, type 3) is ignored, pulses err, and the block stays in IDLE.
- **ACCUM, on each psum_valid:**
  - Active lanes are lane index < 64 >> type. Inactive lanes are written as 0.
  - When tile_cnt==0: buf[row_ptr] ← sign-extended psum_in.
  - Otherwise: buf[row_ptr] ← buf[row_ptr] + sign-extended psum_in, wrapping modulo 2^ACC_W.
  - row_ptr increments. At cfg_rows-1 it wraps to 0 and tile_cnt increments.
  - The row with row_ptr==cfg_rows-1 and tile_cnt==cfg_ktiles-1 moves the FSM to DRAIN.
- **DRAIN:**
  - out_valid=1 and out_data=buf[rd_ptr]. A transfer is out_valid & out_ready, and advances rd_ptr.
  - out_last is high while rd_ptr==cfg_rows-1.
  - The transfer with out_last returns the FSM to IDLE and pulses done.
  - out_data holds stable while out_valid & ~out_ready.
- **Errors (each pulses err for one cycle; the job is otherwise unaffected):**
  - psum_valid in IDLE or DRAIN: the row is dropped.
  - cfg_start in ACCUM or DRAIN: the start is ignored.
- **Simultaneous events in IDLE:** if cfg_start and psum_valid arrive in the same cycle, the start is accepted, the psum row is dropped, and err pulses.
- Buffer contents are not reset. out_data is forced to 0 whenever out_valid=0.

## Timing
- Reset values: out_valid, out_last, busy, done and err are 0; out_data is all 0.
- cfg_start is accepted at edge N. busy=1 from cycle N+1, and the first psum row is accepted at N+1.
- The final psum row is accepted at edge M. out_valid=1 with row 0 from cycle M+1, with no bubble.
- Throughput is one psum row per cycle in ACCUM and one output row per cycle in DRAIN with out_ready held high.
- The last transfer is at edge L. done=1 and busy=0 during cycle L+1. A new cfg_start is accepted at edge L+1.
- err and done are registered one-cycle pulses.
- rst_n assertion mid-job immediately returns the block to IDLE, abandons the job, and zeroes all outputs asynchronously.

## Configuration
- LEGO_PSUM_RELU_EN
  - Defined: in DRAIN, each active out_data lane whose sign bit (ACC_W-1) is set is driven as 0. Buffer contents stay raw.
  - Undefined: out_data is the raw two's-complement accumulator.

## Test plan
- Mode 0, rows=2, ktiles=1, psum rows all-5 then all-(-3), out_ready=1 → out rows all 5 then all 0xFFFFFFFD; out_last on row 1; done one cycle after it.
- Mode 1, rows=1, ktiles=3, psum lanes=10, 20, -7 → lanes 0..31 = 23, lanes 32..63 = 0. With LEGO_PSUM_RELU_EN and a psum of -40 instead of -7, lanes 0..31 = 0.
- Mode 2, rows=4, ktiles=2, out_ready toggling 1,0,0,1 → exactly 4 transfers, out_data stable while stalled, rows equal sum of both tiles.
- Wrap: ktiles=2 with psum lanes 0x7FFFFFFF and 1 → output 0x80000000.
- Errors: cfg_start with rows=0 → err and busy stays 0; psum_valid in IDLE → err and no state change; cfg_start during DRAIN → err and drain completes unchanged.
- rst_n low in the middle of ACCUM → outputs 0 and block in IDLE; a subsequent legal job produces correct results.
